keypad_encoder: RTL and testbench

Scans a 4×4 calculator key matrix, synchronizes and debounces the row returns, and encodes each accepted key press as a 4-bit hex nibble with a one-cycle valid strobe. It is the input-side counterpart of the seven-segment digit decoders: it produces the 4-bit codes that the display path later turns back into segment patterns. It sits between the board keypad pins and the calculator operand/operator logic.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_encoder_row_sync.sv | 27 ++
 rtl/keypad_encoder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner/encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'hF;

    function automatic logic [3:0] col_onecold(input logic [1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = 4'b1110;
            2'd1:    v = 4'b1101;
            2'd2:    v = 4'b1011;
            2'd3:    v = 4'b0111;
            default: v = 4'b1110;
        endcase
        return v;
    endfunction

    // Lowest-index active-low row wins when several rows are down.
    function automatic logic [1:0] row_prio(input logic [3:0] pat);
        logic [1:0] idx;
        if (pat[0] == 1'b0) begin
            idx = 2'd0;
        end else if (pat[1] == 1'b0) begin
            idx = 2'd1;
        end else if (pat[2] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_encoder_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module row_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_row_s
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Resetting to idle keeps a stale low row from looking like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= ROW_IDLE;
            r_sync <= ROW_IDLE;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row_s = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad column scanner, debouncer and hex encoder.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_CNT   = 3,
    parameter int REPEAT_SAMPLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_SAMPLES < 1) begin : g_param_check
        $error("keypad_encoder: parameter out of range");
    end

    logic [3:0]       w_row_s;
    logic             w_sample;
    logic             w_row_idle;
    logic             w_pat_match;
    logic [CNT_W-1:0] w_match_inc;
    logic [CNT_W-1:0] w_rel_inc;
    logic [3:0]       w_pat_src;
    logic             w_accept;
    logic             w_release_done;
    logic             w_col_adv;
    logic             w_repeat;
    state_t           w_state_nxt;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_pat;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_rel_cnt;
    logic [3:0]       r_col;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    row_sync u_row_sync (
        .clk     (clk),
        .rst     (rst),
        .i_row   (row),
        .o_row_s (w_row_s)
    );

    assign w_sample    = (r_div_cnt == DIV_LAST);
    assign w_row_idle  = (w_row_s == ROW_IDLE);
    assign w_pat_match = (w_row_s == r_pat);
    assign w_match_inc = r_match_cnt + CNT_W'(1);
    assign w_rel_inc   = r_rel_cnt + CNT_W'(1);
    // With a one-sample debounce the accept happens from SCAN, before pat is loaded.
    assign w_pat_src   = (r_state == SCAN) ? w_row_s : r_pat;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode; only sample points move the FSM.
    always_comb begin
        w_state_nxt = r_state;
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (!w_row_idle) begin
                        w_state_nxt = (DEBOUNCE_CNT == 1) ? HELD : DEBOUNCE;
                    end else begin
                        w_state_nxt = SCAN;
                    end
                end
                DEBOUNCE: begin
                    if (!w_pat_match) begin
                        w_state_nxt = SCAN;
                    end else if (w_match_inc >= CNT_LAST) begin
                        w_state_nxt = HELD;
                    end else begin
                        w_state_nxt = DEBOUNCE;
                    end
                end
                HELD: begin
                    if (w_row_idle) begin
                        w_state_nxt = (DEBOUNCE_CNT == 1) ? SCAN : RELEASE;
                    end else begin
                        w_state_nxt = HELD;
                    end
                end
                RELEASE: begin
                    if (!w_row_idle) begin
                        w_state_nxt = HELD;
                    end else if (w_rel_inc >= CNT_LAST) begin
                        w_state_nxt = SCAN;
                    end else begin
                        w_state_nxt = RELEASE;
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM output decode: accept, release and column-advance events.
    always_comb begin
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        w_col_adv      = 1'b0;
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    w_accept  = !w_row_idle && (DEBOUNCE_CNT == 1);
                    w_col_adv = w_row_idle;
                end
                DEBOUNCE: begin
                    w_accept  = w_pat_match && (w_match_inc >= CNT_LAST);
                    w_col_adv = !w_pat_match;
                end
                HELD: begin
                    w_release_done = w_row_idle && (DEBOUNCE_CNT == 1);
                    w_col_adv      = w_row_idle && (DEBOUNCE_CNT == 1);
                end
                RELEASE: begin
                    w_release_done = w_row_idle && (w_rel_inc >= CNT_LAST);
                    w_col_adv      = w_row_idle && (w_rel_inc >= CNT_LAST);
                end
                default: begin
                    w_accept       = 1'b0;
                    w_release_done = 1'b0;
                    w_col_adv      = 1'b0;
                end
            endcase
        end else begin
            w_accept       = 1'b0;
            w_release_done = 1'b0;
            w_col_adv      = 1'b0;
        end
    end

    // Dwell counter, column drive and debounce/release counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_col_idx   <= 2'd0;
            r_col       <= col_onecold(2'd0);
            r_pat       <= ROW_IDLE;
            r_match_cnt <= '0;
            r_rel_cnt   <= '0;
        end else begin
            r_div_cnt <= w_sample ? '0 : r_div_cnt + DIV_W'(1);
            if (w_col_adv) begin
                r_col_idx <= r_col_idx + 2'd1;
                r_col     <= col_onecold(r_col_idx + 2'd1);
            end
            if (w_sample) begin
                case (r_state)
                    SCAN: begin
                        if (!w_row_idle) begin
                            r_pat       <= w_row_s;
                            r_match_cnt <= CNT_W'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (w_pat_match) begin
                            r_match_cnt <= w_match_inc;
                        end
                    end
                    HELD: begin
                        if (w_row_idle) begin
                            r_rel_cnt <= CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (w_row_idle) begin
                            r_rel_cnt <= w_rel_inc;
                        end
                    end
                    default: begin
                        r_match_cnt <= '0;
                        r_rel_cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SAMPLES);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_inc;

    assign w_rep_inc = r_rep_cnt + REP_W'(1);
    assign w_repeat  = w_sample && (r_state == HELD) && !w_row_idle && (w_rep_inc == REP_LAST);

    // Repeat counter restarts on entry to HELD and on a release bounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (w_accept) begin
            r_rep_cnt <= '0;
        end else if (w_sample) begin
            case (r_state)
                HELD: begin
                    if (!w_row_idle) begin
                        r_rep_cnt <= w_repeat ? '0 : w_rep_inc;
                    end
                end
                RELEASE: begin
                    if (!w_row_idle) begin
                        r_rep_cnt <= '0;
                    end
                end
                default: r_rep_cnt <= r_rep_cnt;
            endcase
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // Registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= w_accept || w_repeat;
            if (w_accept) begin
                r_key_code <= {row_prio(w_pat_src), r_col_idx};
            end
            if (w_accept) begin
                r_key_held <= 1'b1;
            end else if (w_release_done) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder with a physical 4x4 matrix model.
module tb_keypad_encoder;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int RS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row = 4'hF;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks   = 0;
    int failures = 0;

    logic [15:0] keys      = 16'h0000;
    logic        use_force = 1'b1;
    logic [3:0]  force_row = 4'hF;
    logic [3:0]  exp_q[$];

    always #5 clk = ~clk;

    keypad_encoder #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CNT   (DC),
        .REPEAT_SAMPLES (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    function automatic logic [3:0] onecold(input int idx);
        logic [3:0] v;
        v = 4'hF;
        v[idx] = 1'b0;
        return v;
    endfunction

    // Rows follow the driven column through pressed switches.
    task automatic apply_row();
        logic [3:0] r;
        r = 4'hF;
        if (use_force) begin
            r = force_row;
        end else begin
            for (int rr = 0; rr < 4; rr++)
                for (int cc = 0; cc < 4; cc++)
                    if (keys[rr*4+cc] && col[cc] == 1'b0) r[rr] = 1'b0;
        end
        row = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_row();
    endtask

    task automatic align_col(input int idx, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            prev = col;
            step();
            if (col == onecold(idx) && prev != col) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        use_force = 1'b1;
        force_row = 4'hF;
        keys = 16'h0000;
        repeat (3) step();
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", col); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", key_held); end
    endtask

    task automatic test_scan();
        rst = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            checks++;
            if (col !== onecold((k / SD) % 4)) begin
                failures++; $display("FAIL scan_col k=%0d got=%b exp=%b", k, col, onecold((k / SD) % 4));
            end
            checks++;
            if (key_valid !== 1'b0) begin failures++; $display("FAIL scan_valid k=%0d got=%b exp=0", k, key_valid); end
        end
    endtask

    task automatic test_press_release();
        bit ok;
        logic [3:0] e;
        use_force = 1'b0;
        keys = 16'h0000;
        align_col(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL press_align got=timeout exp=col1"); end
        keys[2*4+1] = 1'b1;
        apply_row();
        exp_q.push_back(4'h9);
        for (int j = 1; j <= 24; j++) begin
            step();
            checks++;
            if (key_valid !== (j == 12)) begin failures++; $display("FAIL press_valid j=%0d got=%b exp=%b", j, key_valid, (j == 12)); end
            if (key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL press_unexpected got=%h exp=none", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e) begin failures++; $display("FAIL press_code got=%h exp=%h", key_code, e); end
                end
                checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press_held got=%b exp=1", key_held); end
            end
            if (j == 12) begin
                keys = 16'h0000;
                apply_row();
            end
            if (j > 12 && j < 24) begin
                checks++;
                if (key_held !== 1'b1 || col !== 4'b1101) begin
                    failures++; $display("FAIL release_hold j=%0d got=%b/%b exp=1/1101", j, key_held, col);
                end
            end
            if (j == 24) begin
                checks++;
                if (key_held !== 1'b0 || col !== 4'b1011) begin
                    failures++; $display("FAIL release_done got=%b/%b exp=0/1011", key_held, col);
                end
            end
        end
    endtask

    task automatic test_bounce();
        bit ok;
        use_force = 1'b1;
        force_row = 4'hF;
        align_col(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bounce_align got=timeout exp=col0"); end
        force_row = 4'b1011;
        apply_row();
        for (int j = 1; j <= 20; j++) begin
            step();
            checks++;
            if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid j=%0d got=%b exp=0", j, key_valid); end
            if (j == 4) begin
                checks++; if (col !== 4'b1110) begin failures++; $display("FAIL bounce_freeze got=%b exp=1110", col); end
                force_row = 4'hF;
            end
            if (j == 8) begin
                checks++; if (col !== 4'b1101) begin failures++; $display("FAIL bounce_resume got=%b exp=1101", col); end
                force_row = 4'b1011;
            end
            if (j == 12) begin
                checks++; if (col !== 4'b1101) begin failures++; $display("FAIL bounce_freeze2 got=%b exp=1101", col); end
                force_row = 4'hF;
            end
            if (j == 16) begin
                checks++; if (col !== 4'b1011) begin failures++; $display("FAIL bounce_resume2 got=%b exp=1011", col); end
            end
            apply_row();
        end
    endtask

    task automatic test_multi_row();
        bit ok;
        logic [3:0] e;
        use_force = 1'b0;
        keys = 16'h0000;
        align_col(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL multi_align got=timeout exp=col0"); end
        keys[1*4+0] = 1'b1;
        keys[3*4+0] = 1'b1;
        apply_row();
        exp_q.push_back(4'h4);
        for (int j = 1; j <= 24; j++) begin
            step();
            checks++;
            if (key_valid !== (j == 12)) begin failures++; $display("FAIL multi_valid j=%0d got=%b exp=%b", j, key_valid, (j == 12)); end
            if (key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL multi_unexpected got=%h exp=none", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e) begin failures++; $display("FAIL multi_code got=%h exp=%h", key_code, e); end
                end
            end
            if (j == 12) begin
                keys = 16'h0000;
                apply_row();
            end
            if (j == 24) begin
                checks++;
                if (key_held !== 1'b0 || col !== 4'b1101) begin
                    failures++; $display("FAIL multi_release got=%b/%b exp=0/1101", key_held, col);
                end
            end
        end
    endtask

    task automatic test_reset_held();
        bit ok;
        logic [3:0] e;
        use_force = 1'b0;
        keys = 16'h0000;
        align_col(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rsth_align got=timeout exp=col2"); end
        keys[0*4+2] = 1'b1;
        apply_row();
        exp_q.push_back(4'h2);
        for (int j = 1; j <= 12; j++) begin
            step();
            checks++;
            if (key_valid !== (j == 12)) begin failures++; $display("FAIL rsth_valid j=%0d got=%b exp=%b", j, key_valid, (j == 12)); end
            if (key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rsth_unexpected got=%h exp=none", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e) begin failures++; $display("FAIL rsth_code got=%h exp=%h", key_code, e); end
                end
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (col !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL rsth_reset got=%b/%h/%b/%b exp=1110/0/0/0", col, key_code, key_valid, key_held);
        end
        rst = 1'b0;
        exp_q.push_back(4'h2);
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (key_valid !== (k == 20)) begin failures++; $display("FAIL rsth_fresh k=%0d got=%b exp=%b", k, key_valid, (k == 20)); end
            if (key_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rsth_unexpected2 got=%h exp=none", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e) begin failures++; $display("FAIL rsth_code2 got=%h exp=%h", key_code, e); end
                end
            end
            if (k == 20) begin
                keys = 16'h0000;
                apply_row();
            end
            if (k == 32) begin
                checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rsth_release got=%b exp=0", key_held); end
            end
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        bit ok;
        bit exp_v;
        logic [3:0] e;
        use_force = 1'b0;
        keys = 16'h0000;
        align_col(3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rep_align got=timeout exp=col3"); end
        keys[3*4+3] = 1'b1;
        apply_row();
        exp_q.push_back(4'hF);
        for (int j = 1; j <= 64; j++) begin
            step();
            exp_v = (j >= 12) && (j <= 52) && (((j - 12) % 20) == 0);
            checks++;
            if (key_valid !== exp_v) begin failures++; $display("FAIL rep_valid j=%0d got=%b exp=%b", j, key_valid, exp_v); end
            if (key_valid && j == 12) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rep_unexpected got=%h exp=none", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e) begin failures++; $display("FAIL rep_code got=%h exp=%h", key_code, e); end
                end
            end else if (key_valid) begin
                checks++; if (key_code !== 4'hF) begin failures++; $display("FAIL rep_code_rpt got=%h exp=f", key_code); end
            end
            if (j == 52) begin
                keys = 16'h0000;
                apply_row();
            end
            if (j == 64) begin
                checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rep_release got=%b exp=0", key_held); end
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_press_release();
        test_bounce();
        test_multi_row();
        test_reset_held();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
